// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS control FSM: opcodes, states and datapath mux selects.
// States 10/11 exist as encodings only; logic targets them only when MC_ADDI_EN is defined.
package mc_pkg;

  localparam int STATE_W = 4;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RTWB   = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } state_t;

  localparam logic [1:0] ALUOP_FUNCT = 2'd0;
  localparam logic [1:0] ALUOP_ADD   = 2'd1;
  localparam logic [1:0] ALUOP_SUB   = 2'd2;

  localparam logic [1:0] SRCB_B      = 2'd0;
  localparam logic [1:0] SRCB_FOUR   = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_IMMSH2 = 2'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

endpackage

// File: rtl/multicycle_control_if.sv
// Control bundle between the multi-cycle FSM (master) and the shared datapath/memory (slave).
interface multicycle_control_if #(
  parameter int STATE_W = 4
);
  logic [5:0]         Op_i;
  logic               mem_ready_i;
  logic               PCWrite_o;
  logic               PCWriteCond_o;
  logic               IorD_o;
  logic               MemRead_o;
  logic               MemWrite_o;
  logic               IRWrite_o;
  logic               MemtoReg_o;
  logic               RegDst_o;
  logic               RegWrite_o;
  logic               ALUSrcA_o;
  logic [1:0]         ALUSrcB_o;
  logic [1:0]         ALUOp_o;
  logic [1:0]         PCSource_o;
  logic               instr_done_o;
  logic               illegal_o;
  logic [STATE_W-1:0] state_o;

  modport master (
    input  Op_i, mem_ready_i,
    output PCWrite_o, PCWriteCond_o, IorD_o, MemRead_o, MemWrite_o, IRWrite_o,
           MemtoReg_o, RegDst_o, RegWrite_o, ALUSrcA_o, ALUSrcB_o, ALUOp_o,
           PCSource_o, instr_done_o, illegal_o, state_o
  );

  modport slave (
    output Op_i, mem_ready_i,
    input  PCWrite_o, PCWriteCond_o, IorD_o, MemRead_o, MemWrite_o, IRWrite_o,
           MemtoReg_o, RegDst_o, RegWrite_o, ALUSrcA_o, ALUSrcB_o, ALUOp_o,
           PCSource_o, instr_done_o, illegal_o, state_o
  );
endinterface

// File: rtl/mc_next_state.sv
// Combinational next-state logic for the multi-cycle control FSM.
// MC_ADDI_EN adds the ADDIEX/ADDIWB path; without it addi decodes as illegal.
module mc_next_state
  import mc_pkg::*;
(
  input  state_t     state_i,
  input  logic [5:0] op_q_i,
  input  logic [5:0] op_dec_i,
  input  logic       mem_ready_i,
  output state_t     state_o,
  output logic       illegal_o
);

  // DECODE dispatches on the live opcode since op_q is only captured on that edge
  always_comb begin
    state_o   = S_FETCH;
    illegal_o = 1'b0;
    case (state_i)
      S_FETCH:  state_o = mem_ready_i ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op_dec_i)
          OP_LW, OP_SW: state_o = S_MEMADR;
          OP_RTYPE:     state_o = S_EXEC;
          OP_BEQ:       state_o = S_BRANCH;
          OP_J:         state_o = S_JUMP;
`ifdef MC_ADDI_EN
          OP_ADDI:      state_o = S_ADDIEX;
`endif
          default: begin
            state_o   = S_FETCH;
            illegal_o = 1'b1;
          end
        endcase
      end
      S_MEMADR: state_o = (op_q_i == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_o = mem_ready_i ? S_MEMWB : S_MEMRD;
      S_MEMWB:  state_o = S_FETCH;
      S_MEMWR:  state_o = mem_ready_i ? S_FETCH : S_MEMWR;
      S_EXEC:   state_o = S_RTWB;
      S_RTWB:   state_o = S_FETCH;
      S_BRANCH: state_o = S_FETCH;
      S_JUMP:   state_o = S_FETCH;
`ifdef MC_ADDI_EN
      S_ADDIEX: state_o = S_ADDIWB;
      S_ADDIWB: state_o = S_FETCH;
`endif
      default:  state_o = S_FETCH;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: Moore strobes decoded from the state register, memory strobes
// gated by mem_ready_i. Optional addi support under MC_ADDI_EN.
module multicycle_control
  import mc_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  multicycle_control_if.master        bus
);

  state_t     state_q, state_d;
  logic [5:0] op_q, op_d;
  logic       illegal_ns;

  mc_next_state u_next (
    .state_i     (state_q),
    .op_q_i      (op_q),
    .op_dec_i    (bus.Op_i),
    .mem_ready_i (bus.mem_ready_i),
    .state_o     (state_d),
    .illegal_o   (illegal_ns)
  );

  always_comb begin
    op_d = (state_q == S_DECODE) ? bus.Op_i : op_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_FETCH;
      op_q    <= OP_RTYPE;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    bus.PCWrite_o     = 1'b0;
    bus.PCWriteCond_o = 1'b0;
    bus.IorD_o        = 1'b0;
    bus.MemRead_o     = 1'b0;
    bus.MemWrite_o    = 1'b0;
    bus.IRWrite_o     = 1'b0;
    bus.MemtoReg_o    = 1'b0;
    bus.RegDst_o      = 1'b0;
    bus.RegWrite_o    = 1'b0;
    bus.ALUSrcA_o     = 1'b0;
    bus.ALUSrcB_o     = SRCB_B;
    bus.ALUOp_o       = ALUOP_FUNCT;
    bus.PCSource_o    = PCSRC_ALU;
    bus.instr_done_o  = 1'b0;
    bus.illegal_o     = 1'b0;
    case (state_q)
      S_FETCH: begin
        bus.MemRead_o  = 1'b1;
        bus.ALUSrcB_o  = SRCB_FOUR;
        bus.ALUOp_o    = ALUOP_ADD;
        bus.PCSource_o = PCSRC_ALU;
        bus.IRWrite_o  = bus.mem_ready_i;
        bus.PCWrite_o  = bus.mem_ready_i;
      end
      S_DECODE: begin
        bus.ALUSrcB_o = SRCB_IMMSH2;
        bus.ALUOp_o   = ALUOP_ADD;
        bus.illegal_o = illegal_ns;
      end
      S_MEMADR: begin
        bus.ALUSrcA_o = 1'b1;
        bus.ALUSrcB_o = SRCB_IMM;
        bus.ALUOp_o   = ALUOP_ADD;
      end
      S_MEMRD: begin
        bus.MemRead_o = 1'b1;
        bus.IorD_o    = 1'b1;
      end
      S_MEMWB: begin
        bus.RegWrite_o   = 1'b1;
        bus.MemtoReg_o   = 1'b1;
        bus.instr_done_o = 1'b1;
      end
      S_MEMWR: begin
        bus.MemWrite_o   = 1'b1;
        bus.IorD_o       = 1'b1;
        bus.instr_done_o = bus.mem_ready_i;
      end
      S_EXEC: begin
        bus.ALUSrcA_o = 1'b1;
        bus.ALUSrcB_o = SRCB_B;
        bus.ALUOp_o   = ALUOP_FUNCT;
      end
      S_RTWB: begin
        bus.RegWrite_o   = 1'b1;
        bus.RegDst_o     = 1'b1;
        bus.instr_done_o = 1'b1;
      end
      S_BRANCH: begin
        bus.ALUSrcA_o     = 1'b1;
        bus.ALUOp_o       = ALUOP_SUB;
        bus.PCWriteCond_o = 1'b1;
        bus.PCSource_o    = PCSRC_ALUOUT;
        bus.instr_done_o  = 1'b1;
      end
      S_JUMP: begin
        bus.PCWrite_o    = 1'b1;
        bus.PCSource_o   = PCSRC_JUMP;
        bus.instr_done_o = 1'b1;
      end
`ifdef MC_ADDI_EN
      S_ADDIEX: begin
        bus.ALUSrcA_o = 1'b1;
        bus.ALUSrcB_o = SRCB_IMM;
        bus.ALUOp_o   = ALUOP_ADD;
      end
      S_ADDIWB: begin
        bus.RegWrite_o   = 1'b1;
        bus.instr_done_o = 1'b1;
      end
`endif
      default: ;
    endcase
    // Reset abandons the instruction: nothing may write or request while it is held
    if (rst_i) begin
      bus.PCWrite_o     = 1'b0;
      bus.PCWriteCond_o = 1'b0;
      bus.MemRead_o     = 1'b0;
      bus.MemWrite_o    = 1'b0;
      bus.IRWrite_o     = 1'b0;
      bus.RegWrite_o    = 1'b0;
      bus.instr_done_o  = 1'b0;
      bus.illegal_o     = 1'b0;
    end
  end

  assign bus.state_o = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_control.sv
// Directed testbench for multicycle_control; each scenario walks a hand-computed per-cycle table.
// Expectations for addi follow MC_ADDI_EN, matching the build of the design.
module tb_multicycle_control;
  import mc_pkg::*;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  multicycle_control_if #(.STATE_W(4)) bus ();

  multicycle_control #(.STATE_W(4)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bit order: PCWrite PCWriteCond IorD MemRead MemWrite IRWrite MemtoReg RegDst RegWrite ALUSrcA ALUSrcB ALUOp PCSource done illegal
  logic [17:0] strobes;
  assign strobes = {bus.PCWrite_o, bus.PCWriteCond_o, bus.IorD_o, bus.MemRead_o, bus.MemWrite_o,
                    bus.IRWrite_o, bus.MemtoReg_o, bus.RegDst_o, bus.RegWrite_o, bus.ALUSrcA_o,
                    bus.ALUSrcB_o, bus.ALUOp_o, bus.PCSource_o, bus.instr_done_o, bus.illegal_o};

  localparam logic [17:0] V_RST  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd1,2'd1,2'd0,1'b0,1'b0};
  localparam logic [17:0] V_FR   = {1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'd1,2'd1,2'd0,1'b0,1'b0};
  localparam logic [17:0] V_FN   = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd1,2'd1,2'd0,1'b0,1'b0};
  localparam logic [17:0] V_DEC  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd3,2'd1,2'd0,1'b0,1'b0};
  localparam logic [17:0] V_ILL  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd3,2'd1,2'd0,1'b0,1'b1};
  localparam logic [17:0] V_MADR = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'd2,2'd1,2'd0,1'b0,1'b0};
  localparam logic [17:0] V_MRD  = {1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,2'd0,1'b0,1'b0};
  localparam logic [17:0] V_MRDR = {1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,2'd0,1'b0,1'b0};
  localparam logic [17:0] V_MWB  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'd0,2'd0,2'd0,1'b1,1'b0};
  localparam logic [17:0] V_MWR0 = {1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,2'd0,1'b0,1'b0};
  localparam logic [17:0] V_MWR1 = {1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,2'd0,1'b1,1'b0};
  localparam logic [17:0] V_EXEC = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'd0,2'd0,2'd0,1'b0,1'b0};
  localparam logic [17:0] V_RTWB = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'd0,2'd0,2'd0,1'b1,1'b0};
  localparam logic [17:0] V_BR   = {1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'd0,2'd2,2'd1,1'b1,1'b0};
  localparam logic [17:0] V_JMP  = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,2'd2,1'b1,1'b0};
`ifdef MC_ADDI_EN
  localparam logic [17:0] V_AEX  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'd2,2'd1,2'd0,1'b0,1'b0};
  localparam logic [17:0] V_AWB  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'd0,2'd0,2'd0,1'b1,1'b0};
`endif

  typedef struct packed {
    logic        rst;
    logic        rdy;
    logic [5:0]  op;
    logic [3:0]  st;
    logic [17:0] vec;
  } cyc_t;

  function automatic cyc_t mk(logic r, logic d, logic [5:0] o, logic [3:0] s, logic [17:0] v);
    mk = {r, d, o, s, v};
  endfunction

  task automatic test_reset();
    cyc_t q[$];
    q.push_back(mk(1'b1, 1'b1, OP_RTYPE, S_FETCH,  V_RST));
    q.push_back(mk(1'b1, 1'b1, OP_RTYPE, S_FETCH,  V_RST));
    q.push_back(mk(1'b0, 1'b1, OP_RTYPE, S_FETCH,  V_FR));
    q.push_back(mk(1'b0, 1'b1, OP_RTYPE, S_DECODE, V_DEC));
    q.push_back(mk(1'b0, 1'b1, OP_RTYPE, S_EXEC,   V_EXEC));
    q.push_back(mk(1'b0, 1'b1, OP_RTYPE, S_RTWB,   V_RTWB));
    q.push_back(mk(1'b0, 1'b0, OP_RTYPE, S_FETCH,  V_FN));
    foreach (q[i]) begin
      rst = q[i].rst; bus.mem_ready_i = q[i].rdy; bus.Op_i = q[i].op;
      #1;
      checks++;
      if (bus.state_o !== q[i].st) begin
        failures++;
        $display("[TB] FAIL reset_state cyc %0d: got %0d want %0d", i, bus.state_o, q[i].st);
      end
      checks++;
      if (strobes !== q[i].vec) begin
        failures++;
        $display("[TB] FAIL reset_strobes cyc %0d: got %h want %h", i, strobes, q[i].vec);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_rtype();
    cyc_t q[$];
    q.push_back(mk(1'b0, 1'b1, OP_RTYPE, S_FETCH,  V_FR));
    q.push_back(mk(1'b0, 1'b1, OP_RTYPE, S_DECODE, V_DEC));
    q.push_back(mk(1'b0, 1'b1, 6'h3f,    S_EXEC,   V_EXEC));
    q.push_back(mk(1'b0, 1'b1, 6'h3f,    S_RTWB,   V_RTWB));
    q.push_back(mk(1'b0, 1'b0, 6'h3f,    S_FETCH,  V_FN));
    foreach (q[i]) begin
      rst = q[i].rst; bus.mem_ready_i = q[i].rdy; bus.Op_i = q[i].op;
      #1;
      checks++;
      if (bus.state_o !== q[i].st) begin
        failures++;
        $display("[TB] FAIL rtype_state cyc %0d: got %0d want %0d", i, bus.state_o, q[i].st);
      end
      checks++;
      if (strobes !== q[i].vec) begin
        failures++;
        $display("[TB] FAIL rtype_strobes cyc %0d: got %h want %h", i, strobes, q[i].vec);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_lw_stall();
    cyc_t q[$];
    q.push_back(mk(1'b0, 1'b0, OP_LW, S_FETCH,  V_FN));
    q.push_back(mk(1'b0, 1'b0, OP_LW, S_FETCH,  V_FN));
    q.push_back(mk(1'b0, 1'b0, OP_LW, S_FETCH,  V_FN));
    q.push_back(mk(1'b0, 1'b1, OP_LW, S_FETCH,  V_FR));
    q.push_back(mk(1'b0, 1'b1, OP_LW, S_DECODE, V_DEC));
    q.push_back(mk(1'b0, 1'b1, OP_SW, S_MEMADR, V_MADR));
    q.push_back(mk(1'b0, 1'b0, OP_SW, S_MEMRD,  V_MRD));
    q.push_back(mk(1'b0, 1'b0, OP_SW, S_MEMRD,  V_MRD));
    q.push_back(mk(1'b0, 1'b1, OP_SW, S_MEMRD,  V_MRD));
    q.push_back(mk(1'b0, 1'b1, OP_SW, S_MEMWB,  V_MWB));
    q.push_back(mk(1'b0, 1'b0, OP_SW, S_FETCH,  V_FN));
    foreach (q[i]) begin
      rst = q[i].rst; bus.mem_ready_i = q[i].rdy; bus.Op_i = q[i].op;
      #1;
      checks++;
      if (bus.state_o !== q[i].st) begin
        failures++;
        $display("[TB] FAIL lw_state cyc %0d: got %0d want %0d", i, bus.state_o, q[i].st);
      end
      checks++;
      if (strobes !== q[i].vec) begin
        failures++;
        $display("[TB] FAIL lw_strobes cyc %0d: got %h want %h", i, strobes, q[i].vec);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_sw_beq_j();
    cyc_t q[$];
    q.push_back(mk(1'b0, 1'b1, OP_SW,  S_FETCH,  V_FR));
    q.push_back(mk(1'b0, 1'b1, OP_SW,  S_DECODE, V_DEC));
    q.push_back(mk(1'b0, 1'b1, OP_LW,  S_MEMADR, V_MADR));
    q.push_back(mk(1'b0, 1'b0, OP_LW,  S_MEMWR,  V_MWR0));
    q.push_back(mk(1'b0, 1'b1, OP_LW,  S_MEMWR,  V_MWR1));
    q.push_back(mk(1'b0, 1'b1, OP_BEQ, S_FETCH,  V_FR));
    q.push_back(mk(1'b0, 1'b0, OP_BEQ, S_DECODE, V_DEC));
    q.push_back(mk(1'b0, 1'b0, OP_BEQ, S_BRANCH, V_BR));
    q.push_back(mk(1'b0, 1'b1, OP_J,   S_FETCH,  V_FR));
    q.push_back(mk(1'b0, 1'b1, OP_J,   S_DECODE, V_DEC));
    q.push_back(mk(1'b0, 1'b1, OP_J,   S_JUMP,   V_JMP));
    q.push_back(mk(1'b0, 1'b0, OP_J,   S_FETCH,  V_FN));
    foreach (q[i]) begin
      rst = q[i].rst; bus.mem_ready_i = q[i].rdy; bus.Op_i = q[i].op;
      #1;
      checks++;
      if (bus.state_o !== q[i].st) begin
        failures++;
        $display("[TB] FAIL swbeqj_state cyc %0d: got %0d want %0d", i, bus.state_o, q[i].st);
      end
      checks++;
      if (strobes !== q[i].vec) begin
        failures++;
        $display("[TB] FAIL swbeqj_strobes cyc %0d: got %h want %h", i, strobes, q[i].vec);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_illegal();
    cyc_t q[$];
    q.push_back(mk(1'b0, 1'b1, 6'h3f,   S_FETCH,  V_FR));
    q.push_back(mk(1'b0, 1'b1, 6'h3f,   S_DECODE, V_ILL));
    q.push_back(mk(1'b0, 1'b1, OP_ADDI, S_FETCH,  V_FR));
`ifdef MC_ADDI_EN
    q.push_back(mk(1'b0, 1'b1, OP_ADDI, S_DECODE, V_DEC));
    q.push_back(mk(1'b0, 1'b1, OP_ADDI, S_ADDIEX, V_AEX));
    q.push_back(mk(1'b0, 1'b1, OP_ADDI, S_ADDIWB, V_AWB));
`else
    q.push_back(mk(1'b0, 1'b1, OP_ADDI, S_DECODE, V_ILL));
`endif
    q.push_back(mk(1'b0, 1'b0, OP_ADDI, S_FETCH,  V_FN));
    foreach (q[i]) begin
      rst = q[i].rst; bus.mem_ready_i = q[i].rdy; bus.Op_i = q[i].op;
      #1;
      checks++;
      if (bus.state_o !== q[i].st) begin
        failures++;
        $display("[TB] FAIL illegal_state cyc %0d: got %0d want %0d", i, bus.state_o, q[i].st);
      end
      checks++;
      if (strobes !== q[i].vec) begin
        failures++;
        $display("[TB] FAIL illegal_strobes cyc %0d: got %h want %h", i, strobes, q[i].vec);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_lw();
    cyc_t q[$];
    q.push_back(mk(1'b0, 1'b1, OP_LW, S_FETCH,  V_FR));
    q.push_back(mk(1'b0, 1'b1, OP_LW, S_DECODE, V_DEC));
    q.push_back(mk(1'b0, 1'b1, OP_LW, S_MEMADR, V_MADR));
    q.push_back(mk(1'b0, 1'b0, OP_LW, S_MEMRD,  V_MRD));
    q.push_back(mk(1'b1, 1'b1, OP_LW, S_MEMRD,  V_MRDR));
    q.push_back(mk(1'b0, 1'b0, OP_LW, S_FETCH,  V_FN));
    foreach (q[i]) begin
      rst = q[i].rst; bus.mem_ready_i = q[i].rdy; bus.Op_i = q[i].op;
      #1;
      checks++;
      if (bus.state_o !== q[i].st) begin
        failures++;
        $display("[TB] FAIL rstmid_state cyc %0d: got %0d want %0d", i, bus.state_o, q[i].st);
      end
      checks++;
      if (strobes !== q[i].vec) begin
        failures++;
        $display("[TB] FAIL rstmid_strobes cyc %0d: got %h want %h", i, strobes, q[i].vec);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (dut.op_q !== 6'b000000) begin
      failures++;
      $display("[TB] FAIL rstmid_op_q: got %b want %b", dut.op_q, 6'b000000);
    end
  endtask

  initial begin
    rst             = 1'b1;
    bus.mem_ready_i = 1'b1;
    bus.Op_i        = OP_RTYPE;
    @(posedge clk); #1;
    test_reset();
    test_rtype();
    test_lw_stall();
    test_sw_beq_j();
    test_illegal();
    test_reset_mid_lw();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle MIPS control FSM that sequences the shared datapath: one ALU, one unified memory port, IR/MDR/A/B/ALUOut registers.
- Takes the opcode from IR and drives per-state control strobes: fetch, decode, execute, memory, writeback.
- Replaces the single-cycle combinational control decode in the multi-cycle CPU variant.
- Stalls on a memory ready handshake.

Parameters:
- STATE_W, 4, width of state register and of state_o.

Ports:
- clk_i  in  1  clock; all state changes on rising edge
- rst_i  in  1  synchronous active-high reset
- Op_i  in  6  opcode field of IR
- mem_ready_i  in  1  memory completes the access this cycle
- PCWrite_o  out  1  unconditional PC write
- PCWriteCond_o  out  1  PC write if ALU zero (beq)
- IorD_o  out  1  memory address: 0=PC, 1=ALUOut
- MemRead_o  out  1  memory read request
- MemWrite_o  out  1  memory write request
- IRWrite_o  out  1  load IR
- MemtoReg_o  out  1  writeback source: 1=MDR, 0=ALUOut
- RegDst_o  out  1  dest register: 1=rd, 0=rt
- RegWrite_o  out  1  register file write
- ALUSrcA_o  out  1  0=PC, 1=A
- ALUSrcB_o  out  2  0=B, 1=const 4, 2=signext imm, 3=signext imm<<2
- ALUOp_o  out  2  0=R-type funct, 1=add, 2=sub
- PCSource_o  out  2  0=ALU result, 1=ALUOut, 2=jump target
- instr_done_o  out  1  one-cycle pulse when an instruction retires
- illegal_o  out  1  one-cycle pulse in DECODE on an unsupported opcode
- state_o  out  STATE_W  current state, for debug

Behaviour:
- Opcodes: R=000000, lw=100011, sw=101011, beq=000100, j=000010, addi=001000 (addi only under the optional feature).
- Moore outputs, decoded from the registered state. Exception: strobes gated by mem_ready_i, noted per state.
- Strobes not listed for a state are 0. ALUSrcB, ALUOp and PCSource default to 0.
- Reset: state=FETCH(0) on the next edge; op_q=0. While rst_i=1, every write or request strobe is forced 0 (PCWrite, PCWriteCond, MemRead, MemWrite, IRWrite, RegWrite, instr_done, illegal). Reset mid-instruction abandons it; no partial writeback.
- Op_i is latched into op_q in DECODE. Later states use op_q, so IR changes are harmless.
- State table:
  - FETCH(0): MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=1, ALUOp=1, PCSource=0. IRWrite and PCWrite = mem_ready_i. Stays in FETCH until mem_ready_i=1, then goes to DECODE.
  - DECODE(1): ALUSrcA=0, ALUSrcB=3, ALUOp=1. Next state: lw/sw->MEMADR, R->EXEC, beq->BRANCH, j->JUMP, addi->ADDIEX. Any other opcode -> FETCH with illegal_o=1.
  - MEMADR(2): ALUSrcA=1, ALUSrcB=2, ALUOp=1. Next: lw->MEMRD, sw->MEMWR.
  - MEMRD(3): MemRead=1, IorD=1. Holds until mem_ready_i, then goes to MEMWB.
  - MEMWB(4): RegWrite=1, MemtoReg=1, RegDst=0, instr_done=1. Next: FETCH.
  - MEMWR(5): MemWrite=1, IorD=1. Holds until mem_ready_i; instr_done=mem_ready_i. Next: FETCH.
  - EXEC(6): ALUSrcA=1, ALUSrcB=0, ALUOp=0. Next: RTWB.
  - RTWB(7): RegWrite=1, RegDst=1, MemtoReg=0, instr_done=1. Next: FETCH.
  - BRANCH(8): ALUSrcA=1, ALUSrcB=0, ALUOp=2, PCWriteCond=1, PCSource=1, instr_done=1. Next: FETCH.
  - JUMP(9): PCWrite=1, PCSource=2, instr_done=1. Next: FETCH.
- Latencies with mem_ready_i tied to 1: lw 5 cycles, sw/R/addi 4 cycles, beq/j 3 cycles.
- MemRead and MemWrite are never both 1. A request is held stable until ready.
- mem_ready_i is ignored in every state that has no memory access.
- Unreachable state encodings recover to FETCH on the next edge.

Optional Feature:
- Macro: MC_ADDI_EN.
- Defined: adds two states.
  - ADDIEX(10): ALUSrcA=1, ALUSrcB=2, ALUOp=1. Next: ADDIWB.
  - ADDIWB(11): RegWrite=1, RegDst=0, MemtoReg=0, instr_done=1. Next: FETCH.
- Undefined: addi decodes as illegal (illegal_o pulse, return to FETCH). States 10/11 are not built.

Decomposition:
- Package mc_pkg holds:
  - opcode localparams (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI)
  - state enum constants S_FETCH..S_ADDIWB
  - ALUOp, ALUSrcB and PCSource encodings
- One sub-module, mc_next_state: combinational next-state logic from (state, op_q/Op_i, mem_ready_i).
- Output decode stays in the top module.

Test Plan:
- rst_i=1 for 2 cycles, then release with ready=1 -> state_o=0 and all strobes 0 during reset; cycle 1 after release shows MemRead=1, IRWrite=1, PCWrite=1.
- R-type (Op=000000), ready=1 -> states 0,1,6,7; RTWB has RegWrite=1, RegDst=1; instr_done pulses once; 4 cycles total.
- lw with ready low 3 cycles in FETCH and 2 cycles in MEMRD -> IRWrite only on the ready cycle; MemRead/IorD=1 held through MEMRD; total 5+5=10 cycles; MemtoReg=1 in MEMWB.
- sw then beq then j -> MemWrite=1 only in MEMWR; BRANCH shows PCWriteCond=1, ALUOp=2, PCSource=1; JUMP shows PCWrite=1, PCSource=2; no RegWrite in any of them.
- Op=111111 -> illegal_o=1 in DECODE, next state FETCH, no write strobes. Op=001000 gives the same result without MC_ADDI_EN; with MC_ADDI_EN it runs 0,1,10,11 and ADDIWB has RegWrite=1, RegDst=0.
- rst_i asserted during MEMRD -> next state FETCH, RegWrite never asserted for that lw, op_q=0.
